// File: rtl/line_buffer_5x5.sv
// rtl/line_buffer_5x5.sv - raster-to-column front end for the 5x5 window buffer
// Four cascaded line memories turn a raster pixel stream into 5-row columns.
module line_buffer_5x5 #(
    parameter int COLS = 5,
    parameter int ROWS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic [7:0] S1_o,
    output logic [7:0] S2_o,
    output logic [7:0] S3_o,
    output logic [7:0] S4_o,
    output logic [7:0] S5_o,
    output logic       valid_o,
    output logic [9:0] col_o,
    output logic [9:0] row_o,
    output logic       frame_done_o
);

    localparam int AW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t     state_q, state_d;
    logic [9:0] c_q, c_d, r_q, r_d;
    logic [7:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d, s5_q, s5_d;
    logic       valid_q, valid_d, frame_done_q, frame_done_d;
    logic [9:0] col_q, col_d, row_q, row_d;

    // lm_q[0] holds row r-1, lm_q[3] holds row r-4 at each column
    logic [7:0] lm_q [4][COLS];

    logic [AW-1:0] addr;
    logic          col_last, row_last;

    assign addr     = c_q[AW-1:0];
    assign col_last = (c_q == 10'(COLS - 1));
    assign row_last = (r_q == 10'(ROWS - 1));

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        r_d          = r_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        s3_d         = s3_q;
        s4_d         = s4_q;
        s5_d         = s5_q;
        col_d        = col_q;
        row_d        = row_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;

        if (valid_i) begin
            s5_d  = data_i;
            s4_d  = lm_q[0][addr];
            s3_d  = lm_q[1][addr];
            s2_d  = lm_q[2][addr];
            s1_d  = lm_q[3][addr];
            col_d = c_q;
            row_d = r_q;
            if (col_last) begin
                c_d = 10'd0;
                r_d = row_last ? 10'd0 : r_q + 10'd1;
            end else begin
                c_d = c_q + 10'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (valid_i) state_d = FILL;
            end
            FILL: begin
                if (valid_i && col_last && (r_q == 10'd3)) state_d = STREAM;
            end
            STREAM: begin
                if (valid_i) begin
                    valid_d = 1'b1;
                    if (col_last && row_last) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                // a pixel here is (0,0) of the next frame, so no bubble
                state_d = valid_i ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            c_q          <= 10'd0;
            r_q          <= 10'd0;
            s1_q         <= 8'd0;
            s2_q         <= 8'd0;
            s3_q         <= 8'd0;
            s4_q         <= 8'd0;
            s5_q         <= 8'd0;
            col_q        <= 10'd0;
            row_q        <= 10'd0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            r_q          <= r_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            s4_q         <= s4_d;
            s5_q         <= s5_d;
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line memories are not reset; stale rows are overwritten during FILL
    always_ff @(posedge clk) begin
        if (!rst && valid_i) begin
            lm_q[0][addr] <= data_i;
            lm_q[1][addr] <= lm_q[0][addr];
            lm_q[2][addr] <= lm_q[1][addr];
            lm_q[3][addr] <= lm_q[2][addr];
        end
    end

    assign S1_o         = s1_q;
    assign S2_o         = s2_q;
    assign S3_o         = s3_q;
    assign S4_o         = s4_q;
    assign S5_o         = s5_q;
    assign valid_o      = valid_q;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign frame_done_o = frame_done_q;

endmodule
